// File: rtl/sevenseg_scroller_pkg.sv
// rtl/sevenseg_scroller_pkg.sv - shared character codes and state encoding for the scroller
package sevenseg_scroller_pkg;

  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_HYPHEN = 8'h2d;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SCROLL = 1'b1
  } state_t;

endpackage

// File: rtl/sevenseg_scroller_if.sv
// rtl/sevenseg_scroller_if.sv - message byte stream into the scroller
interface sevenseg_scroller_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_char;
  logic       wr_last;

  modport master (output wr_valid, output wr_char, output wr_last, input wr_ready);
  modport slave  (input wr_valid, input wr_char, input wr_last, output wr_ready);
endinterface

// File: rtl/sevenseg_scroller_tick.sv
// rtl/sevenseg_scroller_tick.sv - scroll-rate divider with synchronous clear
module sevenseg_scroller_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = !clear && (cnt_q == CW'(DIV - 1));

  // Count clk cycles while enabled; wrap to zero on the tick cycle
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/sevenseg_scroller.sv
// rtl/sevenseg_scroller.sv - stores an ASCII message and scrolls a 4-char window across it
module sevenseg_scroller
  import sevenseg_scroller_pkg::*;
#(
  parameter int MAX_LEN  = 32,
  parameter int TICK_DIV = 25_000_000,
  parameter bit LOOP     = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  sevenseg_scroller_if.slave         wr,
  input  logic                       stop,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 display_0,
  output logic [7:0]                 display_1,
  output logic [7:0]                 display_2,
  output logic [7:0]                 display_3,
  output logic [1:0]                 decplace
);
  localparam int PW = $clog2(MAX_LEN);
  localparam int WW = $clog2(MAX_LEN + 4) + 1;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q;
  logic [WW-1:0]   len_q;
  logic [WW-1:0]   win_q;
  logic            done_q, done_d;
  logic [7:0]      msg_q  [MAX_LEN];
  logic [7:0]      disp_q [4];
  logic [7:0]      vch    [4];
  logic [WW-1:0]   pos    [4];

  logic fire;
  logic last_beat;
  logic tick;
  logic win_end;

  assign wr.wr_ready = !rst && (state_q == ST_IDLE);
  assign fire        = wr.wr_valid && wr.wr_ready;
  // A full buffer closes the message even without wr_last
  assign last_beat   = fire && (wr.wr_last || (wr_ptr_q == PW'(MAX_LEN - 1)));
  assign win_end     = (win_q == len_q + WW'(3));

  assign busy      = (state_q == ST_SCROLL);
  assign done      = done_q;
  assign decplace  = 2'b00;
  assign display_0 = disp_q[0];
  assign display_1 = disp_q[1];
  assign display_2 = disp_q[2];
  assign display_3 = disp_q[3];

  sevenseg_scroller_tick #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q != ST_SCROLL),
    .tick  (tick)
  );

  // Next state: stop wins over a coincident tick and never pulses done
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (last_beat) state_d = ST_SCROLL;
      end
      ST_SCROLL: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tick && win_end && !LOOP) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, write pointer, message length and window position
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      len_q    <= '0;
      win_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (state_q == ST_IDLE) begin
        if (last_beat) begin
          len_q    <= WW'(wr_ptr_q) + WW'(1);
          wr_ptr_q <= '0;
          win_q    <= '0;
        end else if (fire) begin
          wr_ptr_q <= wr_ptr_q + PW'(1);
        end
      end else if (stop) begin
        wr_ptr_q <= '0;
      end else if (tick) begin
        win_q <= win_end ? '0 : win_q + WW'(1);
      end
    end
  end

  // Message storage; no reset needed since len gates every read
  always_ff @(posedge clk) begin
    if (fire) msg_q[wr_ptr_q] <= wr.wr_char;
  end

  // Virtual stream: four leading spaces, the message, then trailing spaces
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      pos[k] = win_q + WW'(k);
      vch[k] = CH_SPACE;
      if (pos[k] >= WW'(4) && pos[k] < len_q + WW'(4)) begin
        vch[k] = msg_q[PW'(pos[k] - WW'(4))];
      end
    end
  end

  // Registered display characters; blank whenever not scrolling
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst || state_q != ST_SCROLL || state_d != ST_SCROLL) begin
        disp_q[k] <= CH_SPACE;
      end else begin
        disp_q[k] <= vch[k];
      end
    end
  end
endmodule
